// File: rtl/mult_pkg.sv
// Shared constants for the signed multiplier: default width, product width
// and the representable result range.
package mult_pkg;

    localparam int DEF_W = 8;
    localparam int PW    = 2 * DEF_W;

    function automatic int prod_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int prod_min(input int w);
        return -(1 << (w - 1));
    endfunction

    localparam int PROD_MAX = prod_max(DEF_W);
    localparam int PROD_MIN = prod_min(DEF_W);

endpackage

// File: rtl/mult_pp_array.sv
// Combinational Baugh-Wooley signed multiplier: W partial-product rows summed
// by a ripple chain seeded with the sign-correction constant.
module mult_pp_array
    import mult_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] p
);

    localparam int FW = 2 * W;

    // Folds the negative weights of the mixed-sign terms: +2^W and +2^(2W-1).
    localparam logic [FW-1:0] CORR = (FW'(1) << W) | (FW'(1) << (FW - 1));

    logic [W:0][FW-1:0] acc;

    assign acc[0] = CORR;

    for (genvar j = 0; j < W; j++) begin : g_row
        logic [W-1:0] pp;
        for (genvar i = 0; i < W; i++) begin : g_bit
            // Terms with exactly one sign bit carry negative weight; invert them.
            if ((i == W - 1) != (j == W - 1)) begin : g_inv
                assign pp[i] = ~(a[i] & b[j]);
            end else begin : g_pos
                assign pp[i] = a[i] & b[j];
            end
        end
        assign acc[j+1] = acc[j] + ({{W{1'b0}}, pp} << j);
    end

    assign p = acc[W];

endmodule

// File: rtl/multiplier_s8.sv
// Two-stage signed multiplier: stage 1 registers the full product, stage 2
// range-checks it and saturates or wraps into W bits.
module multiplier_s8
    import mult_pkg::*;
#(
    parameter int W   = DEF_W,
    parameter bit SAT = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    output logic [W-1:0] prod,
    output logic         ovf
);

    localparam int FW = 2 * W;
    localparam logic [W-1:0] MAX_V = W'(prod_max(W));
    localparam logic [W-1:0] MIN_V = W'(prod_min(W));

    logic [FW-1:0] p_full;
    logic [FW-1:0] p_q;
    logic [2:1]    vld_pipe;
    logic          ovf_next;
    logic [W-1:0]  prod_next;

    mult_pp_array #(.W(W)) u_pp (
        .a (a),
        .b (b),
        .p (p_full)
    );

    // The top W+1 bits must be a pure sign extension for the result to fit.
    assign ovf_next = ~((&p_q[FW-1:W-1]) | ~(|p_q[FW-1:W-1]));

    always_comb begin
        prod_next = p_q[W-1:0];
        if (SAT && ovf_next) begin
            prod_next = p_q[FW-1] ? MIN_V : MAX_V;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe <= '0;
            p_q      <= '0;
            prod     <= '0;
            ovf      <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[1], in_valid};
            if (in_valid) begin
                p_q <= p_full;
            end
            if (vld_pipe[1]) begin
                prod <= prod_next;
                ovf  <= ovf_next;
            end
        end
    end

    assign out_valid = vld_pipe[2];

endmodule

// File: tb/tb_multiplier_s8.sv
// Bench for multiplier_s8: saturating and wrapping instances side by side,
// checked against an integer-multiply reference with a due-cycle scoreboard.
module tb_multiplier_s8;

    localparam int W = 8;

    logic         clk      = 1'b0;
    logic         rst      = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] a        = '0;
    logic [W-1:0] b        = '0;

    logic         ov_s, ov_w, of_s, of_w;
    logic [W-1:0] pr_s, pr_w;
    logic [19:0]  obs;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] last_s = '0;
    logic [7:0] last_w = '0;
    logic       last_o = 1'b0;

    always #5 clk = ~clk;

    multiplier_s8 #(.W(W), .SAT(1'b1)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
        .out_valid(ov_s), .prod(pr_s), .ovf(of_s)
    );

    multiplier_s8 #(.W(W), .SAT(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
        .out_valid(ov_w), .prod(pr_w), .ovf(of_w)
    );

    assign obs = {ov_s, pr_s, of_s, ov_w, pr_w, of_w};

    function automatic logic [19:0] pack(input logic v, input logic [7:0] s,
                                         input logic [7:0] w, input logic o);
        return {v, s, o, v, w, o};
    endfunction

    function automatic int ref_p(input logic [7:0] x, input logic [7:0] y);
        return int'($signed(x)) * int'($signed(y));
    endfunction

    function automatic logic ref_ovf(input int p);
        return (p > 127) || (p < -128);
    endfunction

    function automatic logic [7:0] ref_sat(input int p);
        if (!ref_ovf(p)) return p[7:0];
        return (p < 0) ? 8'h80 : 8'h7F;
    endfunction

    function automatic logic [7:0] pick();
        case ($urandom_range(7))
            0: return 8'h80;
            1: return 8'h7F;
            2: return 8'h00;
            3: return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++;
        if (obs !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_hold got=%h exp=%h", obs, 20'h0);
        end
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if (obs !== 20'h0) begin
                n_fail++;
                $display("FAIL reset_release got=%h exp=%h", obs, 20'h0);
            end
        end
        last_s = '0; last_w = '0; last_o = 1'b0;
    endtask

    task automatic test_directed();
        logic [7:0] da  [9] = '{8'hF1, 8'h10, 8'hF0, 8'h80, 8'h80, 8'h7F, 8'hFF, 8'h00, 8'h80};
        logic [7:0] db  [9] = '{8'h02, 8'h08, 8'h08, 8'hFF, 8'h80, 8'h7F, 8'hFF, 8'h80, 8'h7F};
        logic [7:0] ds  [9] = '{8'hE2, 8'h7F, 8'h80, 8'h7F, 8'h7F, 8'h7F, 8'h01, 8'h00, 8'h80};
        logic [7:0] dw  [9] = '{8'hE2, 8'h80, 8'h80, 8'h80, 8'h00, 8'h01, 8'h01, 8'h00, 8'h80};
        logic       dov [9] = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b1,  1'b1,  1'b0,  1'b0,  1'b1};
        logic [19:0] exp;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            a = da[i]; b = db[i]; in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom);
            exp = pack(1'b0, last_s, last_w, last_o);
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL dir_latency case=%0d got=%h exp=%h", i, obs, exp);
            end
            @(negedge clk);
            last_s = ds[i]; last_w = dw[i]; last_o = dov[i];
            exp = pack(1'b1, last_s, last_w, last_o);
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL dir_result case=%0d got=%h exp=%h", i, obs, exp);
            end
            @(negedge clk);
            exp = pack(1'b0, last_s, last_w, last_o);
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL dir_single case=%0d got=%h exp=%h", i, obs, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ba [4] = '{8'h03, 8'hF9, 8'h00, 8'h0B};
        logic [7:0] bb [4] = '{8'h05, 8'h09, 8'h80, 8'hF5};
        logic [7:0] br [4] = '{8'h0F, 8'hC1, 8'h00, 8'h87};
        logic [19:0] exp;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (k >= 2 && k <= 5) begin
                last_s = br[k-2]; last_w = br[k-2]; last_o = 1'b0;
                exp = pack(1'b1, last_s, last_w, last_o);
            end else begin
                exp = pack(1'b0, last_s, last_w, last_o);
            end
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL b2b k=%0d got=%h exp=%h", k, obs, exp);
            end
            if (k < 4) begin
                a = ba[k]; b = bb[k]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_reset_inflight();
        logic [19:0] exp;
        @(negedge clk);
        a = 8'h03; b = 8'h04; in_valid = 1'b1;
        @(negedge clk);
        a = 8'hFB; b = 8'h06;
        @(negedge clk);
        in_valid = 1'b0;
        exp = pack(1'b1, 8'h0C, 8'h0C, 1'b0);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL inflight_pre got=%h exp=%h", obs, exp);
        end
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (obs !== 20'h0) begin
            n_fail++;
            $display("FAIL inflight_async got=%h exp=%h", obs, 20'h0);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            n_checks++;
            if (obs !== 20'h0) begin
                n_fail++;
                $display("FAIL inflight_after got=%h exp=%h", obs, 20'h0);
            end
        end
        last_s = '0; last_w = '0; last_o = 1'b0;
    endtask

    task automatic test_random();
        int due_q [$];
        int p_q   [$];
        int sent = 0;
        int k = 0;
        int p;
        logic [19:0] exp;
        while (sent < 1000 || due_q.size() != 0) begin
            @(negedge clk);
            if (due_q.size() != 0 && due_q[0] == k) begin
                p = p_q.pop_front();
                void'(due_q.pop_front());
                last_s = ref_sat(p); last_w = p[7:0]; last_o = ref_ovf(p);
                exp = pack(1'b1, last_s, last_w, last_o);
            end else begin
                exp = pack(1'b0, last_s, last_w, last_o);
            end
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL rand k=%0d got=%h exp=%h", k, obs, exp);
            end
            if (sent < 1000 && $urandom_range(3) != 0) begin
                a = pick(); b = pick(); in_valid = 1'b1;
                p_q.push_back(ref_p(a, b));
                due_q.push_back(k + 2);
                sent++;
            end else begin
                in_valid = 1'b0;
            end
            k++;
            if (k > 6000) begin
                n_checks++;
                n_fail++;
                $display("FAIL rand_timeout got=%0d exp=%0d", sent, 1000);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_inflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
